// File: rtl/i2c_pkg.sv
// Shared types and default timing constants for the I2C transaction arbiter.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_DONE,
        ST_RECOVER
    } state_t;

    // Cycles allowed for the controller to raise BUSY after start.
    localparam int DEFAULT_TIMEOUT = 4096;
    // Cycles the controller is held in reset after a fault.
    localparam int DEFAULT_RECOVER = 512;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches upward from last+1 (wrapping)
// and returns the first pending requester as one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Walk the candidates in priority order; the first pending one wins.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ))
                sum = sum - (IDX_W+1)'(NUM_REQ);
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C controller between NUM_REQ requesters: round-robin grant,
// start/busy handshake with timeout, completion reporting and fault recovery.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BYTES = 1,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int RECOVER   = DEFAULT_RECOVER
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_op,
    input  logic [NUM_REQ-1:0]             req_2b,
    input  logic [7*NUM_REQ-1:0]           req_addr,
    input  logic [8*NUM_BYTES*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [NUM_REQ-1:0]             err,
    output logic [8*NUM_BYTES-1:0]         rdata,
    output logic                           ctl_start,
    output logic                           ctl_op,
    output logic                           ctl_2b,
    output logic [6:0]                     ctl_addr,
    output logic [8*NUM_BYTES-1:0]         ctl_dtx,
    output logic                           ctl_rst_n,
    input  logic                           ctl_busy,
    input  logic                           ctl_nack,
    input  logic [8*NUM_BYTES-1:0]         ctl_qrx
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int DW      = 8*NUM_BYTES;
    localparam int CNT_MAX = (TIMEOUT > RECOVER) ? TIMEOUT : RECOVER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECOVER - 1);

    state_t             state, state_nxt;
    logic               busy_meta, busy_s;
    logic               nack_meta, nack_s;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               sel_op, sel_2b;
    logic [6:0]         sel_addr;
    logic [DW-1:0]      sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req  (req),
        .last (last_grant),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // Mux the winning requester's transaction fields.
    always_comb begin
        sel_op   = 1'b0;
        sel_2b   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_op   = req_op[i];
                sel_2b   = req_2b[i];
                sel_addr = req_addr[i*7 +: 7];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Two-flop synchronizers for the controller status lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
            nack_meta <= 1'b0;
            nack_s    <= 1'b0;
        end else begin
            busy_meta <= ctl_busy;
            busy_s    <= busy_meta;
            nack_meta <= ctl_nack;
            nack_s    <= nack_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; err is already registered while in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arb_any) state_nxt = ST_ISSUE;
            ST_ISSUE:   if (busy_s) state_nxt = ST_RUN;
                        else if (cnt == TO_LAST) state_nxt = ST_DONE;
            ST_RUN:     if (!busy_s) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = (|err) ? ST_RECOVER : ST_IDLE;
            ST_RECOVER: if (cnt == RC_LAST) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs; done/err/rdata are loaded on entry to DONE so the
    // pulses coincide with the DONE cycle while gnt is still high.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt        <= '0;
            done       <= '0;
            err        <= '0;
            rdata      <= '0;
            ctl_start  <= 1'b0;
            ctl_op     <= 1'b0;
            ctl_2b     <= 1'b0;
            ctl_addr   <= '0;
            ctl_dtx    <= '0;
            ctl_rst_n  <= 1'b1;
            last_grant <= IDX_W'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt        <= arb_gnt;
                        last_grant <= arb_idx;
                        ctl_op     <= sel_op;
                        ctl_2b     <= sel_2b;
                        ctl_addr   <= sel_addr;
                        ctl_dtx    <= sel_data;
                        ctl_start  <= 1'b1;
                        cnt        <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (busy_s) begin
                        ctl_start <= 1'b0;
                    end else if (cnt == TO_LAST) begin
                        ctl_start <= 1'b0;
                        done      <= gnt;
                        err       <= gnt;
                        rdata     <= ctl_qrx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!busy_s) begin
                        done  <= gnt;
                        err   <= nack_s ? gnt : '0;
                        rdata <= ctl_qrx;
                    end
                end
                ST_DONE: begin
                    gnt <= '0;
                    if (|err) begin
                        ctl_rst_n <= 1'b0;
                        cnt       <= '0;
                    end
                end
                ST_RECOVER: begin
                    if (cnt == RC_LAST) ctl_rst_n <= 1'b1;
                    else                cnt       <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a behavioural controller model and a
// completion scoreboard.
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, req_op = '0, req_2b = '0;
    logic [27:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt, done, err;
    logic [7:0]  rdata, ctl_dtx, ctl_qrx;
    logic        ctl_start, ctl_op, ctl_2b, ctl_rst_n;
    logic [6:0]  ctl_addr;
    logic        ctl_busy = 1'b0, ctl_nack = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         idx;
        bit         err;
        bit         chk;
        logic [7:0] rd;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // controller model knobs
    int         busy_len   = 200;
    bit         no_busy    = 1'b0;
    bit         model_nack = 1'b0;
    logic [7:0] model_qrx  = 8'h00;
    int         mstate = 0, bcnt = 0;

    always #5 clk = ~clk;

    i2c_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    (req_op),
        .req_2b    (req_2b),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ctl_start (ctl_start),
        .ctl_op    (ctl_op),
        .ctl_2b    (ctl_2b),
        .ctl_addr  (ctl_addr),
        .ctl_dtx   (ctl_dtx),
        .ctl_rst_n (ctl_rst_n),
        .ctl_busy  (ctl_busy),
        .ctl_nack  (ctl_nack),
        .ctl_qrx   (ctl_qrx)
    );

    initial ctl_qrx = 8'h00;

    // Behavioural I2C controller: BUSY for busy_len cycles after start,
    // optional sticky NACK, Q_RX updated at BUSY fall.
    always @(posedge clk) begin
        if (rst || !ctl_rst_n) begin
            mstate   <= 0;
            ctl_busy <= 1'b0;
            ctl_nack <= 1'b0;
        end else begin
            case (mstate)
                0: if (ctl_start && !no_busy) begin
                       ctl_busy <= 1'b1;
                       bcnt     <= 0;
                       mstate   <= 1;
                   end
                1: begin
                       bcnt <= bcnt + 1;
                       if (model_nack && bcnt == 5) ctl_nack <= 1'b1;
                       if (bcnt == busy_len - 1) begin
                           ctl_busy <= 1'b0;
                           ctl_qrx  <= model_qrx;
                           mstate   <= 2;
                       end
                   end
                default: if (!ctl_start) mstate <= 0;
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the next expectation.
    always @(negedge clk) begin
        if (!rst && (done != 4'b0 || err != 4'b0)) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                mon_e = q.pop_front();
                check("done_onehot", 32'(done), 32'(1) << mon_e.idx);
                check("err_pulse", 32'(err), mon_e.err ? (32'(1) << mon_e.idx) : 32'h0);
                if (mon_e.chk) check("rdata", 32'(rdata), 32'(mon_e.rd));
            end
        end
    end

    task automatic wait_gnt(input int limit);
        int k = 0;
        while (gnt == 4'b0 && k < limit) begin @(negedge clk); k++; end
        check("gnt_seen", 32'(gnt != 4'b0), 32'h1);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done == 4'b0 && k < limit) begin @(negedge clk); k++; end
        check("done_seen", 32'(done != 4'b0), 32'h1);
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lowcnt, viol, hi, k;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_start", 32'(ctl_start), 32'h0);
        check("rst_addr", 32'(ctl_addr), 32'h0);
        check("rst_rstn", 32'(ctl_rst_n), 32'h1);
        rst = 1'b0;

        // single write to 0x50 with payload 0xA5
        @(negedge clk);
        req_addr[6:0] = 7'h50; req_data[7:0] = 8'hA5; req_op[0] = 1'b0;
        busy_len = 200;
        q.push_back('{0, 1'b0, 1'b0, 8'h00});
        req[0] = 1'b1;
        wait_gnt(10);
        check("wr_gnt", 32'(gnt), 32'h1);
        check("wr_addr", 32'(ctl_addr), 32'h50);
        check("wr_dtx", 32'(ctl_dtx), 32'hA5);
        check("wr_op", 32'(ctl_op), 32'h0);
        check("wr_start", 32'(ctl_start), 32'h1);
        wait_done(1000);
        check("wr_addr_hold", 32'(ctl_addr), 32'h50);
        check("wr_dtx_hold", 32'(ctl_dtx), 32'hA5);
        req[0] = 1'b0;

        // requester drops req mid-transaction; completion still reported
        @(negedge clk);
        req_addr[13:7] = 7'h22;
        q.push_back('{1, 1'b0, 1'b0, 8'h00});
        req[1] = 1'b1;
        wait_gnt(10);
        check("drop_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        @(negedge clk);
        wait_done(1000);

        // contention from reset: 0,1,2,3,0
        pulse_rst();
        busy_len = 20;
        for (int i = 0; i < 5; i++) q.push_back('{i % 4, 1'b0, 1'b0, 8'h00});
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wait_done(500);
        end
        req = 4'h0;

        // read from requester 2
        @(negedge clk);
        req_addr[20:14] = 7'h11; req_op[2] = 1'b1; model_qrx = 8'h3C;
        q.push_back('{2, 1'b0, 1'b1, 8'h3C});
        req[2] = 1'b1;
        @(negedge clk);
        wait_done(500);
        req[2] = 1'b0; req_op[2] = 1'b0;

        // NACK: error, 512-cycle controller reset, no grant meanwhile
        @(negedge clk);
        model_nack = 1'b1;
        q.push_back('{3, 1'b1, 1'b0, 8'h00});
        req[3] = 1'b1;
        @(negedge clk);
        wait_done(500);
        req[3] = 1'b0; model_nack = 1'b0;
        q.push_back('{0, 1'b0, 1'b0, 8'h00});
        req[0] = 1'b1;
        @(negedge clk);
        lowcnt = 0; viol = 0; k = 0;
        while (!ctl_rst_n && k < 2000) begin
            lowcnt++;
            if (gnt != 4'b0) viol++;
            @(negedge clk); k++;
        end
        check("nack_rstn_low", 32'(lowcnt), 32'd512);
        check("nack_no_gnt", 32'(viol), 32'd0);
        check("nack_idle_gap", 32'(gnt), 32'h0);
        wait_gnt(10);
        check("post_rec_gnt", 32'(gnt), 32'h1);
        wait_done(500);
        req[0] = 1'b0;

        // timeout: BUSY never rises
        @(negedge clk);
        no_busy = 1'b1;
        q.push_back('{1, 1'b1, 1'b0, 8'h00});
        req[1] = 1'b1;
        wait_gnt(10);
        hi = 0; k = 0;
        while (ctl_start && k < 6000) begin hi++; @(negedge clk); k++; end
        check("to_start_high", 32'(hi), 32'd4096);
        check("to_done", 32'(done), 32'h2);
        check("to_err", 32'(err), 32'h2);
        req[1] = 1'b0;
        @(negedge clk);
        check("to_recover", 32'(ctl_rst_n), 32'h0);
        k = 0;
        while (!ctl_rst_n && k < 1000) begin @(negedge clk); k++; end
        check("to_released", 32'(ctl_rst_n), 32'h1);
        no_busy = 1'b0;

        // reset during RUN abandons the transaction
        @(negedge clk);
        busy_len = 200;
        req_addr[20:14] = 7'h33;
        req[2] = 1'b1;
        wait_gnt(10);
        repeat (30) @(negedge clk);
        check("run_busy", 32'(ctl_busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_gnt", 32'(gnt), 32'h0);
        check("mid_done", 32'(done), 32'h0);
        check("mid_err", 32'(err), 32'h0);
        check("mid_start", 32'(ctl_start), 32'h0);
        check("mid_addr", 32'(ctl_addr), 32'h0);
        check("mid_rdata", 32'(rdata), 32'h0);
        check("mid_rstn", 32'(ctl_rst_n), 32'h1);
        req[2] = 1'b0;
        rst = 1'b0;
        repeat (300) @(negedge clk);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
